// File: rtl/alt_pulse_pkg.sv
// Shared types and constants for the alternating pulse receiver.
// Contents: FSM state enum, error-bit indices, timer width.
package alt_pulse_pkg;

    // Width of the gap and high-length timers
    localparam int unsigned TMR_W = 8;

    // Bit positions inside out_err
    localparam int unsigned ERR_OVF   = 0;
    localparam int unsigned ERR_STUCK = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/pulse_edge_det.sv
// Previous-sample register with rise/fall strobes for a single-bit line.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   pulse_i   - line sampled every cycle
//   rise_c    - pulse_i=1 while previous sample was 0 (combinational)
//   fall_c    - pulse_i=0 while previous sample was 1 (combinational)
module pulse_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic pulse_i,
    output logic rise_c,
    output logic fall_c
);

    logic pulse_q;

    // Previous sample, updated unconditionally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= pulse_i;
        end
    end

    assign rise_c = pulse_i & ~pulse_q;
    assign fall_c = ~pulse_i & pulse_q;

endmodule

// File: rtl/alt_pulse_rx.sv
// Alternating pulse train receiver: counts rising edges within a burst,
// ends the burst after GAP_TIMEOUT low samples and hands the count out
// through a valid/ready report.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   pulse_in   - pulse line, synchronous to clk
//   out_valid  - report available (held until accepted)
//   out_ready  - consumer accepts the report
//   out_count  - pulses counted in the burst (saturating)
//   out_err    - [0] count overflow, [1] stuck-high abort
//   busy       - receiver not in IDLE
module alt_pulse_rx
    import alt_pulse_pkg::*;
#(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned GAP_TIMEOUT = 4,
    parameter int unsigned MAX_HIGH    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic [1:0]       out_err,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [1:0]         err_q, err_d;
    logic [TMR_W-1:0]   gap_q, gap_d;
    logic [TMR_W-1:0]   hi_len_q, hi_len_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic               rise_c, fall_c;

    pulse_edge_det u_edge (
        .clk     (clk),
        .rst     (rst),
        .pulse_i (pulse_in),
        .rise_c  (rise_c),
        .fall_c  (fall_c)
    );

    // State and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            err_q       <= '0;
            gap_q       <= '0;
            hi_len_q    <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            err_q       <= err_d;
            gap_q       <= gap_d;
            hi_len_q    <= hi_len_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state and counter update. In HIGH the previous sample is always 1
    // and in LOW always 0, so fall_c/rise_c are exactly "line low"/"line high".
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        err_d    = err_q;
        gap_d    = gap_q;
        hi_len_d = hi_len_q;

        unique case (state_q)
            IDLE: begin
                if (rise_c) begin
                    state_d  = HIGH;
                    count_d  = CNT_W'(1);
                    hi_len_d = TMR_W'(1);
                end
            end
            HIGH: begin
                if (fall_c) begin
                    gap_d   = TMR_W'(1);
                    // A timeout of one ends the burst on the first low
                    state_d = (gap_d == TMR_W'(GAP_TIMEOUT)) ? DONE : LOW;
                end else begin
                    hi_len_d = hi_len_q + TMR_W'(1);
                    if (hi_len_d == TMR_W'(MAX_HIGH)) begin
                        err_d[ERR_STUCK] = 1'b1;
                        state_d          = DONE;
                    end
                end
            end
            LOW: begin
                if (rise_c) begin
                    state_d  = HIGH;
                    hi_len_d = TMR_W'(1);
                    if (count_q == CNT_MAX) begin
                        err_d[ERR_OVF] = 1'b1;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end else begin
                    gap_d = gap_q + TMR_W'(1);
                    if (gap_d == TMR_W'(GAP_TIMEOUT)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // Line activity is ignored until the report is taken
                if (out_ready) begin
                    state_d  = IDLE;
                    count_d  = '0;
                    err_d    = '0;
                    gap_d    = '0;
                    hi_len_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    assign out_valid = out_valid_q;
    assign out_count = count_q;
    assign out_err   = err_q;
    assign busy      = busy_q;

endmodule
